stage_mem: RTL
==============

# stage_mem

Memory-access pipeline stage directly downstream of the execute stage. Takes the ALU result as the effective address and the forwarded register-B data as store data. Performs byte/half/word loads and stores over a single-outstanding ready-handshake data bus, and hands a registered result to writeback. Non-memory instructions pass through with one cycle of latency. Misaligned accesses and bus timeouts are flagged without issuing a bus cycle.

## Interface
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- REG_WIDTH, 5, destination register index width.
- TIMEOUT, 16, maximum cycles spent waiting for i_memReady before a bus error is raised; must be ≥1.
- i_clock  in  1  clock; all state changes on rising edge.
- i_reset  in  1  reset; synchronous, active-low.
- i_valid  in  1  upstream holds a valid instruction.
- o_ready  out  1  stage can accept; a transfer occurs when i_valid && o_ready.
- i_result  in  DATA_WIDTH  ALU result: effective address, or writeback value for non-memory ops.
- i_dataB  in  DATA_WIDTH  store data.
- i_memRd, i_memWr  in  1 each  load / store request; never both set.
- i_memAccess  in  2  MemAccess: BYTE=0, HALF=1, WORD=2.
- i_memUnsigned  in  1  zero-extend loads (LBU/LHU).
- i_regAddr  in  REG_WIDTH  destination register, passed through.
- i_regWrEnable  in  1  register write request, passed through.
- o_memAddr  out  DATA_WIDTH  word-aligned bus address.
- o_memRdEnable, o_memWrEnable  out  1 each  bus strobes.
- o_memByteEnable  out  4  byte lanes.
- o_memWrData  out  DATA_WIDTH  lane-replicated store data.
- i_memRdData  in  DATA_WIDTH  read data; valid when i_memReady.
- i_memReady  in  1  bus completes the current cycle.
- o_valid  out  1  one-cycle pulse; result and fields below are valid.
- o_result  out  DATA_WIDTH  extended load data, or i_result for non-loads.
- o_regAddr  out  REG_WIDTH  registered destination register.
- o_regWrEnable  out  1  registered write enable; forced to 0 on any error.
- o_misaligned  out  1  misaligned access error, qualified by o_valid.
- o_busError  out  1  timeout error, qualified by o_valid.

## Operation
- States:
  - IDLE: o_ready=1.
  - BUS: bus cycle in progress, o_ready=0.
- IDLE, accepting a non-memory op: register outputs and pulse o_valid next cycle; o_result=i_result.
- IDLE, accepting a memory op:
  - Misaligned if HALF with addr[0]=1, or WORD with addr[1:0]≠0.
  - If misaligned: no bus cycle; o_valid pulse next cycle with o_misaligned=1, o_regWrEnable=0, o_result=i_result.
  - If aligned: latch request, go to BUS, clear the timeout counter.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0].
  - HALF: 4'b0011<<addr[1:0].
  - WORD: 4'b1111.
- Store data lanes:
  - BYTE: {4{d[7:0]}}.
  - HALF: {2{d[15:0]}}.
  - WORD: d.
- o_memAddr = {addr[31:2],2'b00}. Strobes, address, enables and write data are registered and held constant throughout BUS.
- BUS with i_memReady=1:
  - Strobes drop at the edge; go to IDLE; o_valid pulse.
  - Loads: i_memRdData shifted right by addr[1:0]*8, then sign- or zero-extended per access size and i_memUnsigned.
  - Stores: o_result=i_result.
- BUS with i_memReady=0: increment the counter. When it reaches TIMEOUT-1 without ready: drop strobes, go to IDLE, o_valid pulse with o_busError=1, o_regWrEnable=0.
- i_memReady outside BUS is ignored.
- Reset (i_reset=0 at an edge):
  - State IDLE, counter 0.
  - All registered outputs 0: o_valid, strobes, o_memByteEnable, o_memAddr, o_memWrData, o_result, o_regAddr, o_regWrEnable, o_misaligned, o_busError.
  - o_ready=0 while i_reset=0.
  - Reset mid-BUS abandons the transaction: strobes low after that edge, no o_valid.

## Timing
- Non-memory and misaligned ops: o_valid exactly 1 cycle after acceptance; o_ready stays 1, so back-to-back issue is allowed.
- Memory op accepted at edge N:
  - Strobes high from N+1.
  - Earliest completion when i_memReady=1 during cycle N+1: o_valid at N+2.
  - Latency = 2 + wait cycles.
- o_ready returns to 1 in the same cycle o_valid pulses, so the next op can be accepted then.
- Timeout: o_valid/o_busError exactly TIMEOUT+1 cycles after acceptance when ready never arrives.
- No downstream backpressure; writeback always consumes o_valid.

## Structure
- Types package gains the MemAccess enum (BYTE/HALF/WORD) and a MEM_TIMEOUT default constant.
- The state enum is local to the module.
- One combinational sub-module, load_store_align:
  - Inputs: address low bits, access size, unsigned flag, store data, raw read data.
  - Outputs: byte enables, lane-replicated write data, extended load data.
  - Shared with a future instruction-fetch path.
- Counter width: $clog2(TIMEOUT)+1.

## Test plan
- ADD passthrough: i_result=0x1234_5678, i_regAddr=5 → o_valid next cycle, o_result=0x1234_5678, o_regAddr=5, no strobes.
- LB signed at 0x1003, i_memRdData=0x80FF_0000, ready after 2 waits:
  - o_memAddr=0x1000, o_memByteEnable=4'b1000.
  - o_result=0xFFFF_FF80, o_valid 4 cycles after acceptance.
- SH at 0x2002, i_dataB=0xAAAA_BEEF, ready immediately → o_memWrData=0xBEEF_BEEF, o_memByteEnable=4'b1100, o_valid at N+2.
- LW at 0x3001 → o_misaligned=1, o_regWrEnable=0, no bus strobe at any cycle.
- LW with i_memReady held 0, TIMEOUT=4 → strobes drop, o_busError=1 at N+5, then ADD accepted same cycle completes normally.
- i_reset=0 during BUS → strobes low next cycle, no o_valid; after release, an LHU at 0x0002 with data 0x8001_0000 gives o_result=0x0000_8001.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared types for the memory-access stage: access size encoding and bus timeout default.
package stage_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_access_e;

  localparam int MEM_TIMEOUT = 16;

  // Size code 3 is undefined; it is treated as never misaligned.
  function automatic logic is_misaligned(input mem_access_e acc, input logic [1:0] lo);
    case (acc)
      HALF:    is_misaligned = lo[0];
      WORD:    is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_load_store_align.sv
// Combinational lane steering: byte enables and replicated store data going out,
// right-justified and sign/zero-extended load data coming back.
module load_store_align
  import stage_mem_pkg::*;
(
  input  logic [1:0]  i_addrLo,
  input  mem_access_e i_access,
  input  logic        i_unsigned,
  input  logic [31:0] i_wrData,
  input  logic [31:0] i_rdData,
  output logic [3:0]  o_byteEnable,
  output logic [31:0] o_wrData,
  output logic [31:0] o_rdData
);

  logic [31:0] rd_shift;

  assign rd_shift = i_rdData >> {i_addrLo, 3'b000};

  always_comb begin
    o_byteEnable = 4'b1111;
    o_wrData     = i_wrData;
    o_rdData     = rd_shift;
    case (i_access)
      BYTE: begin
        o_byteEnable = 4'b0001 << i_addrLo;
        o_wrData     = {4{i_wrData[7:0]}};
        o_rdData     = {{24{rd_shift[7] & ~i_unsigned}}, rd_shift[7:0]};
      end
      HALF: begin
        o_byteEnable = 4'b0011 << i_addrLo;
        o_wrData     = {2{i_wrData[15:0]}};
        o_rdData     = {{16{rd_shift[15] & ~i_unsigned}}, rd_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: one outstanding bus cycle, registered result to writeback,
// misaligned accesses and bus timeouts reported instead of completing.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int TIMEOUT    = MEM_TIMEOUT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [DATA_WIDTH-1:0] i_dataB,
  input  logic                  i_memRd,
  input  logic                  i_memWr,
  input  logic [1:0]            i_memAccess,
  input  logic                  i_memUnsigned,
  input  logic [REG_WIDTH-1:0]  i_regAddr,
  input  logic                  i_regWrEnable,
  output logic [DATA_WIDTH-1:0] o_memAddr,
  output logic                  o_memRdEnable,
  output logic                  o_memWrEnable,
  output logic [3:0]            o_memByteEnable,
  output logic [DATA_WIDTH-1:0] o_memWrData,
  input  logic [DATA_WIDTH-1:0] i_memRdData,
  input  logic                  i_memReady,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [REG_WIDTH-1:0]  o_regAddr,
  output logic                  o_regWrEnable,
  output logic                  o_misaligned,
  output logic                  o_busError
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d, mis_q, mis_d, berr_q, berr_d;
  logic                    rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [3:0]              be_q, be_d;
  logic [REG_WIDTH-1:0]    reg_addr_q, reg_addr_d;
  logic                    reg_we_q, reg_we_d;
  // Request latched while the bus cycle is open; req_result_q also carries addr[1:0].
  logic [DATA_WIDTH-1:0]   req_result_q, req_result_d;
  mem_access_e             req_access_q, req_access_d;
  logic                    req_unsigned_q, req_unsigned_d, req_load_q, req_load_d;
  logic [REG_WIDTH-1:0]    req_reg_addr_q, req_reg_addr_d;
  logic                    req_reg_we_q, req_reg_we_d;

  mem_access_e in_access;
  logic        in_bus;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign in_access = mem_access_e'(i_memAccess);
  assign in_bus    = (state_q == S_BUS);

  // The aligner serves the store side while idle and the load side while on the bus.
  load_store_align u_align (
    .i_addrLo     (in_bus ? req_result_q[1:0] : i_result[1:0]),
    .i_access     (in_bus ? req_access_q : in_access),
    .i_unsigned   (req_unsigned_q),
    .i_wrData     (i_dataB),
    .i_rdData     (i_memRdData),
    .o_byteEnable (al_be),
    .o_wrData     (al_wdata),
    .o_rdData     (al_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    valid_d        = 1'b0;
    mis_d          = 1'b0;
    berr_d         = 1'b0;
    rd_en_d        = rd_en_q;
    wr_en_d        = wr_en_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    result_d       = result_q;
    reg_addr_d     = reg_addr_q;
    reg_we_d       = reg_we_q;
    req_result_d   = req_result_q;
    req_access_d   = req_access_q;
    req_unsigned_d = req_unsigned_q;
    req_load_d     = req_load_q;
    req_reg_addr_d = req_reg_addr_q;
    req_reg_we_d   = req_reg_we_q;
    case (state_q)
      S_IDLE: if (i_valid) begin
        reg_addr_d = i_regAddr;
        result_d   = i_result;
        if (!(i_memRd || i_memWr)) begin
          valid_d  = 1'b1;
          reg_we_d = i_regWrEnable;
        end else if (is_misaligned(in_access, i_result[1:0])) begin
          valid_d  = 1'b1;
          mis_d    = 1'b1;
          reg_we_d = 1'b0;
        end else begin
          state_d        = S_BUS;
          cnt_d          = '0;
          rd_en_d        = i_memRd;
          wr_en_d        = i_memWr;
          addr_d         = {i_result[DATA_WIDTH-1:2], 2'b00};
          be_d           = al_be;
          wdata_d        = al_wdata;
          req_result_d   = i_result;
          req_access_d   = in_access;
          req_unsigned_d = i_memUnsigned;
          req_load_d     = i_memRd;
          req_reg_addr_d = i_regAddr;
          req_reg_we_d   = i_regWrEnable;
        end
      end
      S_BUS: begin
        if (i_memReady || cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          rd_en_d    = 1'b0;
          wr_en_d    = 1'b0;
          valid_d    = 1'b1;
          berr_d     = !i_memReady;
          reg_addr_d = req_reg_addr_q;
          reg_we_d   = req_reg_we_q && i_memReady;
          result_d   = (req_load_q && i_memReady) ? al_rdata : req_result_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      valid_q        <= 1'b0;
      mis_q          <= 1'b0;
      berr_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      wr_en_q        <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      result_q       <= '0;
      reg_addr_q     <= '0;
      reg_we_q       <= 1'b0;
      req_result_q   <= '0;
      req_access_q   <= BYTE;
      req_unsigned_q <= 1'b0;
      req_load_q     <= 1'b0;
      req_reg_addr_q <= '0;
      req_reg_we_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      mis_q          <= mis_d;
      berr_q         <= berr_d;
      rd_en_q        <= rd_en_d;
      wr_en_q        <= wr_en_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      result_q       <= result_d;
      reg_addr_q     <= reg_addr_d;
      reg_we_q       <= reg_we_d;
      req_result_q   <= req_result_d;
      req_access_q   <= req_access_d;
      req_unsigned_q <= req_unsigned_d;
      req_load_q     <= req_load_d;
      req_reg_addr_q <= req_reg_addr_d;
      req_reg_we_q   <= req_reg_we_d;
    end
  end

  assign o_ready         = i_reset && (state_q == S_IDLE);
  assign o_valid         = valid_q;
  assign o_misaligned    = mis_q;
  assign o_busError      = berr_q;
  assign o_memRdEnable   = rd_en_q;
  assign o_memWrEnable   = wr_en_q;
  assign o_memAddr       = addr_q;
  assign o_memByteEnable = be_q;
  assign o_memWrData     = wdata_q;
  assign o_result        = result_q;
  assign o_regAddr       = reg_addr_q;
  assign o_regWrEnable   = reg_we_q;

endmodule
